fault_campaign_ctrl: RTL

Synthesizable fault-campaign sequencer that drives the fault-injectable circuit (`top`) and its golden copy (`logic2`). It applies every input vector to both circuits for every (node, stuck-at value) pair and compares the faulty outputs against the golden outputs. Each detected fault is emitted as a record over a valid/ready handshake. A per-fault coverage mask and a detected-fault count are maintained for the whole campaign.

---
 rtl/fault_campaign_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/fault_campaign_ctrl.sv
// Fault-campaign sequencer: sweeps vec x node x stuck over top/golden
// and reports first (or every) detection via valid/ready.
// Ports: clk, rst, start | vec, sel, stuck -> DUT | fo, go <- circuits
//        busy, done | det_valid/ready, det_node/stuck/vec | cov_mask, det_count
module fault_campaign_ctrl #(
  parameter int N_IN       = 5,
  parameter int N_NODES    = 16,
  parameter int SETTLE     = 2,
  parameter int REPORT_ALL = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [N_IN-1:0]      vec,
  output logic [4:0]           sel,
  output logic                 stuck,
  input  logic [1:0]           fo,
  input  logic [1:0]           go,
  output logic                 busy,
  output logic                 done,
  output logic                 det_valid,
  input  logic                 det_ready,
  output logic [4:0]           det_node,
  output logic                 det_stuck,
  output logic [N_IN-1:0]      det_vec,
  output logic [2*N_NODES-1:0] cov_mask,
  output logic [5:0]           det_count
);

  localparam int MW = 2 * N_NODES;
  localparam int IW = $clog2(MW);
  localparam int CW = $clog2(SETTLE + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_CHECK,
    S_REPORT,
    S_DONE
  } state_t;

  state_t          state, state_n;
  logic [N_IN-1:0] vec_n, dvec_n;
  logic [4:0]      sel_n, dnode_n;
  logic            stuck_n, dstuck_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [MW-1:0]   mask_n;
  logic [5:0]      count_n;

  logic [5:0]      raw;
  logic [IW-1:0]   idx;
  logic            mism, newbit, last, adv;

  assign busy      = (state == S_APPLY) ||
                     (state == S_CHECK) ||
                     (state == S_REPORT);
  assign done      = (state == S_DONE);
  assign det_valid = (state == S_REPORT);

  // mask bit of the current trial: 2*(sel-1)+stuck
  assign raw    = {sel - 5'd1, stuck};
  assign idx    = IW'(raw);
  assign mism   = (fo != go);
  assign newbit = mism && !cov_mask[idx];
  assign last   = (&vec) && (sel == 5'(N_NODES)) && stuck;

  always_comb begin
    state_n  = state;
    vec_n    = vec;
    sel_n    = sel;
    stuck_n  = stuck;
    cnt_n    = cnt;
    dnode_n  = det_node;
    dstuck_n = det_stuck;
    dvec_n   = det_vec;
    mask_n   = cov_mask;
    count_n  = det_count;
    adv      = 1'b0;

    unique case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_n = S_APPLY;
          vec_n   = '0;
          sel_n   = 5'd1;
          stuck_n = 1'b0;
          cnt_n   = '0;
          mask_n  = '0;
          count_n = '0;
        end
      end
      S_APPLY: begin
        if (cnt == CW'(SETTLE - 1)) state_n = S_CHECK;
        else cnt_n = cnt + CW'(1);
      end
      S_CHECK: begin
        if (newbit) begin
          mask_n[idx] = 1'b1;
          count_n     = det_count + 6'd1;
        end
        if (mism && ((REPORT_ALL != 0) || newbit)) begin
          state_n  = S_REPORT;
          dnode_n  = sel;
          dstuck_n = stuck;
          dvec_n   = vec;
        end else begin
          adv = 1'b1;
        end
      end
      S_REPORT: begin
        if (det_ready) adv = 1'b1;
      end
      default: state_n = S_IDLE;
    endcase

    // stuck rolls into node, node rolls into vector
    if (adv) begin
      cnt_n = '0;
      if (last) begin
        state_n = S_DONE;
        vec_n   = '0;
        sel_n   = 5'd0;
        stuck_n = 1'b0;
      end else begin
        state_n = S_APPLY;
        if (!stuck) begin
          stuck_n = 1'b1;
        end else begin
          stuck_n = 1'b0;
          if (sel == 5'(N_NODES)) begin
            sel_n = 5'd1;
            vec_n = vec + N_IN'(1);
          end else begin
            sel_n = sel + 5'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      vec       <= '0;
      sel       <= '0;
      stuck     <= 1'b0;
      cnt       <= '0;
      det_node  <= '0;
      det_stuck <= 1'b0;
      det_vec   <= '0;
      cov_mask  <= '0;
      det_count <= '0;
    end else begin
      state     <= state_n;
      vec       <= vec_n;
      sel       <= sel_n;
      stuck     <= stuck_n;
      cnt       <= cnt_n;
      det_node  <= dnode_n;
      det_stuck <= dstuck_n;
      det_vec   <= dvec_n;
      cov_mask  <= mask_n;
      det_count <= count_n;
    end
  end

endmodule
